// File: rtl/reg_init_pkg.sv
// Shared constants for the register-init loader: frame header, FSM state
// encodings and the Y byte-count helper.
package reg_init_pkg;

  localparam logic [7:0] HDR = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_GET_X   = 3'd1;
  localparam state_t ST_GET_Y   = 3'd2;
  localparam state_t ST_GET_SUM = 3'd3;
  localparam state_t ST_COMMIT  = 3'd4;

  // Number of stream bytes needed to carry a w-bit Y value.
  function automatic int unsigned y_bytes(input int unsigned w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/reg_init_shift.sv
// Little-endian byte assembler: each shifted byte enters at the top, so after
// BYTES shifts the first byte received sits in bits [7:0].
module reg_init_shift #(
  parameter int unsigned BYTES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_shift,
  input  logic [7:0]           i_data,
  output logic [BYTES*8-1:0]   o_data
);

  logic [BYTES*8-1:0] r_data;

  generate
    if (BYTES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst || i_clr) begin
          r_data <= '0;
        end else if (i_shift) begin
          r_data <= i_data;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst || i_clr) begin
          r_data <= '0;
        end else if (i_shift) begin
          r_data <= {i_data, r_data[BYTES*8-1:8]};
        end
      end
    end
  endgenerate

  assign o_data = r_data;

endmodule

// File: rtl/reg_init_loader.sv
// Register-init loader: assembles HDR/X/Y[/SUM] frames from a byte stream and
// commits x_init/y_init. Define REG_INIT_LOADER_CHECKSUM_EN for the XOR check byte.
module reg_init_loader
  import reg_init_pkg::*;
#(
  parameter int unsigned X_W   = 3,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned X_RST = 0,
  parameter int unsigned Y_RST = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  output logic [X_W-1:0] x_init,
  output logic [Y_W-1:0] y_init,
  output logic           init_update,
  output logic           frame_err,
  output logic           busy
);

  localparam int unsigned Y_BYTES = y_bytes(Y_W);
  localparam logic [2:0]  LAST_Y  = 3'(Y_BYTES - 1);

  state_t               r_state;
  logic [2:0]           r_cnt;
  logic [X_W-1:0]       r_x_sh;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic                 r_upd;
  logic                 r_err;

  logic                 w_hs;
  logic                 w_clr;
  logic                 w_shift;
  logic                 w_last_y;
  logic [Y_BYTES*8-1:0] w_y_full;

  assign in_ready    = (r_state != ST_COMMIT);
  assign busy        = (r_state != ST_IDLE);
  assign w_hs        = in_valid & in_ready;
  assign w_clr       = (r_state == ST_IDLE) & w_hs & (in_data == HDR);
  assign w_shift     = (r_state == ST_GET_Y) & w_hs;
  assign w_last_y    = (r_cnt == LAST_Y);

  assign x_init      = r_x;
  assign y_init      = r_y;
  assign init_update = r_upd;
  assign frame_err   = r_err;

  reg_init_shift #(
    .BYTES (Y_BYTES)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_data  (in_data),
    .o_data  (w_y_full)
  );

`ifdef REG_INIT_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  // Running XOR over the raw X and Y bytes, compared against the trailing byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_hs && r_state == ST_GET_X) begin
      r_sum <= in_data;
    end else if (w_shift) begin
      r_sum <= r_sum ^ in_data;
    end
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every branch sees
  // the pre-edge values; reset is synchronous, so rst is just the first test.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x_sh  <= '0;
      r_x     <= X_W'(X_RST);
      r_y     <= Y_W'(Y_RST);
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            if (in_data == HDR) begin
              r_state <= ST_GET_X;
              r_cnt   <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_GET_X: begin
          if (w_hs) begin
            r_x_sh  <= in_data[X_W-1:0];
            r_state <= ST_GET_Y;
          end
        end
        ST_GET_Y: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 3'd1;
            if (w_last_y) begin
`ifdef REG_INIT_LOADER_CHECKSUM_EN
              r_state <= ST_GET_SUM;
`else
              r_state <= ST_COMMIT;
`endif
            end
          end
        end
`ifdef REG_INIT_LOADER_CHECKSUM_EN
        ST_GET_SUM: begin
          if (w_hs) begin
            if (in_data == r_sum) begin
              r_state <= ST_COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
`endif
        ST_COMMIT: begin
          r_x     <= r_x_sh;
          r_y     <= w_y_full[Y_W-1:0];
          r_upd   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
